can_rx_bit_timing: RTL and testbench

//  Receive front end of the CAN controller, directly downstream of the can_rx pin and upstream of the frame decoder.

---
 rtl/can_rx_bit_timing_pkg.sv | 15 +
 rtl/can_rx_bit_timing_sync.sv | 29 ++
 rtl/can_rx_bit_timing.sv | 193 +++++++++++++++++++
 tb/tb_can_rx_bit_timing.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_rx_bit_timing_pkg.sv
// Shared definitions for the CAN receive bit-timing front end.
package can_rx_bit_timing_pkg;

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StIdle = 2'd1,
        StBit  = 2'd2
    } rx_state_e;

    // Equal-bit run length that forces a stuff bit; shared with the TX stuffer.
    localparam int unsigned StuffLimit = 5;
    // Consecutive recessive bits that mark the bus as idle.
    localparam int unsigned IdleBits   = 11;

endpackage

// File: rtl/can_rx_bit_timing_sync.sv
// Two-flop synchroniser for an asynchronous bus level with falling-edge detect.
module can_rx_bit_timing_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic rx_s,
    output logic fall
);

    logic rx_meta;
    logic rx_s_d;

    // Synchronise the pin and keep one delayed copy for edge detection (idle = recessive)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_async;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Recessive-to-dominant transition
    assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/can_rx_bit_timing.sv
// CAN receive front end: quantum timing, hard/soft sync, sampling and bit destuffing.
module can_rx_bit_timing
    import can_rx_bit_timing_pkg::*;
#(
    parameter int unsigned BRP        = 5,
    parameter int unsigned TQ_PER_BIT = 10,
    parameter int unsigned SAMPLE_TQ  = 7,
    parameter int unsigned SJW        = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic can_rx,
    input  logic en,
    input  logic destuff_en,
    input  logic frame_done,
    output logic sample_stb,
    output logic sample_bit,
    output logic bit_valid,
    output logic bit_data,
    output logic stuff_err,
    output logic bus_idle
);

    localparam int unsigned BrpW = (BRP > 1) ? $clog2(BRP) : 1;
    localparam int unsigned TqW  = $clog2(TQ_PER_BIT + 1);

    localparam logic [BrpW-1:0] BrpLast    = BrpW'(BRP - 1);
    localparam logic [TqW-1:0]  TqBit      = TqW'(TQ_PER_BIT);
    localparam logic [TqW-1:0]  TqLast     = TqW'(TQ_PER_BIT - 1);
    localparam logic [TqW-1:0]  SampleTq   = TqW'(SAMPLE_TQ);
    localparam logic [TqW-1:0]  SampleLast = TqW'(SAMPLE_TQ - 1);
    localparam logic [TqW-1:0]  Sjw        = TqW'(SJW);
    localparam logic [2:0]      RunMax     = 3'(StuffLimit);
    localparam logic [3:0]      RecMax     = 4'(IdleBits);

    rx_state_e       state;
    logic            rx_s;
    logic            fall;
    logic [BrpW-1:0] brp_cnt;
    logic [TqW-1:0]  tq_cnt;
    logic            resync_armed;
    logic [2:0]      run_cnt;
    logic            last_bit;
    logic            sof_pending;
    logic [3:0]      rec_cnt;

    logic            tq_tick;
    logic            sample_point;
    logic            resync;
    logic [TqW-1:0]  resync_adj;
    logic [TqW-1:0]  resync_tq;
    logic            resync_wrap;

    can_rx_bit_timing_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_async (can_rx),
        .rx_s     (rx_s),
        .fall     (fall)
    );

    assign tq_tick      = (brp_cnt == BrpLast);
    assign sample_point = (state == StBit) && tq_tick && (tq_cnt == SampleLast);
    // Soft sync only on an edge after a recessive sample, once per bit, never at tq 0
    assign resync       = (state == StBit) && fall && resync_armed && (tq_cnt != '0) && sample_bit;

    // Phase correction target: pull back within seg1, or jump forward toward the bit end
    always_comb begin
        resync_adj  = '0;
        resync_tq   = '0;
        resync_wrap = 1'b0;
        if (tq_cnt < SampleTq) begin
            resync_adj = (tq_cnt < Sjw) ? tq_cnt : Sjw;
            resync_tq  = tq_cnt - resync_adj;
        end else begin
            resync_adj = ((TqBit - tq_cnt) < Sjw) ? (TqBit - tq_cnt) : Sjw;
            if ((tq_cnt + resync_adj) >= TqBit) begin
                resync_wrap = 1'b1;
            end else begin
                resync_tq = tq_cnt + resync_adj;
            end
        end
    end

    // Prescaler and quantum counter; held at zero outside BIT so hard sync starts a clean bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brp_cnt      <= '0;
            tq_cnt       <= '0;
            resync_armed <= 1'b1;
        end else if (state != StBit) begin
            brp_cnt      <= '0;
            tq_cnt       <= '0;
            resync_armed <= 1'b1;
        end else begin
            brp_cnt <= tq_tick ? '0 : brp_cnt + 1'b1;
            if (resync) begin
                // A resync that reaches the bit end starts a fresh bit, so it rearms
                tq_cnt       <= resync_tq;
                resync_armed <= resync_wrap;
            end else if (tq_tick) begin
                if (tq_cnt == TqLast) begin
                    tq_cnt       <= '0;
                    resync_armed <= 1'b1;
                end else begin
                    tq_cnt <= tq_cnt + 1'b1;
                end
            end
        end
    end

    // Receiver state, sampling, destuffing and idle detection with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StOff;
            sample_stb  <= 1'b0;
            sample_bit  <= 1'b1;
            bit_valid   <= 1'b0;
            bit_data    <= 1'b1;
            stuff_err   <= 1'b0;
            bus_idle    <= 1'b1;
            run_cnt     <= '0;
            last_bit    <= 1'b0;
            sof_pending <= 1'b0;
            rec_cnt     <= '0;
        end else begin
            sample_stb <= 1'b0;
            bit_valid  <= 1'b0;
            stuff_err  <= 1'b0;
            if (!en) begin
                state      <= StOff;
                sample_bit <= 1'b1;
                bit_data   <= 1'b1;
            end else begin
                unique case (state)
                    StOff: state <= StIdle;
                    StIdle: begin
                        if (fall) begin
                            state       <= StBit;
                            run_cnt     <= 3'd1;
                            last_bit    <= 1'b0;
                            sof_pending <= 1'b1;
                            rec_cnt     <= '0;
                            bus_idle    <= 1'b0;
                        end
                    end
                    StBit: begin
                        if (frame_done || bus_idle) begin
                            state <= StIdle;
                        end
                        if (sample_point) begin
                            sample_stb <= 1'b1;
                            sample_bit <= rx_s;
                            if (rx_s) begin
                                rec_cnt <= (rec_cnt == RecMax) ? rec_cnt : rec_cnt + 1'b1;
                            end else begin
                                rec_cnt <= '0;
                            end
                            bus_idle <= rx_s && (rec_cnt >= RecMax - 1'b1);
                            if (sof_pending) begin
                                // SOF already counts as the first bit of the run
                                bit_valid   <= 1'b1;
                                bit_data    <= rx_s;
                                run_cnt     <= 3'd1;
                                last_bit    <= rx_s;
                                sof_pending <= 1'b0;
                            end else if (!destuff_en) begin
                                bit_valid <= 1'b1;
                                bit_data  <= rx_s;
                                run_cnt   <= 3'd1;
                                last_bit  <= rx_s;
                            end else if (run_cnt == RunMax) begin
                                if (rx_s != last_bit) begin
                                    run_cnt  <= 3'd1;
                                    last_bit <= rx_s;
                                end else begin
                                    stuff_err <= 1'b1;
                                end
                            end else begin
                                bit_valid <= 1'b1;
                                bit_data  <= rx_s;
                                run_cnt   <= (rx_s == last_bit) ? run_cnt + 1'b1 : 3'd1;
                                last_bit  <= rx_s;
                            end
                        end
                    end
                    default: state <= StOff;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_rx_bit_timing.sv
// Scoreboard bench for can_rx_bit_timing: a bit-level frame model predicts every sample strobe.
module tb_can_rx_bit_timing;

    logic clk = 1'b0;
    logic rst;
    logic can_rx;
    logic en;
    logic destuff_en;
    logic frame_done;
    logic sample_stb;
    logic sample_bit;
    logic bit_valid;
    logic bit_data;
    logic stuff_err;
    logic bus_idle;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    can_rx_bit_timing dut (
        .clk        (clk),
        .rst        (rst),
        .can_rx     (can_rx),
        .en         (en),
        .destuff_en (destuff_en),
        .frame_done (frame_done),
        .sample_stb (sample_stb),
        .sample_bit (sample_bit),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .stuff_err  (stuff_err),
        .bus_idle   (bus_idle)
    );

    // gap: 0 = check latency from SOF, >0 = clocks since previous strobe, <0 = unchecked
    typedef struct {
        bit sbit;
        bit valid;
        bit data;
        bit err;
        bit idle;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sof_cyc  = 0;
    int   last_stb = 0;

    // Transmitted bit list: level, destuff flag, duration in clocks, expected strobe gap
    int lv[$];
    int ds[$];
    int du[$];
    int gp[$];

    localparam int BitClk = 50;
    // SOF driven just after edge 0, captured at edge 1, strobe registered 37 clocks later
    localparam int SofLat = 38;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe is matched against the next predicted bit
    always @(negedge clk) begin
        if (!rst) begin
            if ((bit_valid || stuff_err) && !sample_stb) begin
                n_checks++;
                n_fail++;
                $display("FAIL orphan_pulse at cycle %0d: got valid=%0b err=%0b, expected strobe",
                         cyc, bit_valid, stuff_err);
            end
            if (sample_stb) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe at cycle %0d: got strobe, expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sample_bit", int'(sample_bit), int'(mon_e.sbit));
                    check("bit_valid", int'(bit_valid), int'(mon_e.valid));
                    if (mon_e.valid) check("bit_data", int'(bit_data), int'(mon_e.data));
                    check("stuff_err", int'(stuff_err), int'(mon_e.err));
                    check("bus_idle", int'(bus_idle), int'(mon_e.idle));
                    if (mon_e.gap == 0) check("sof_latency", cyc - sof_cyc, SofLat);
                    else if (mon_e.gap > 0) check("bit_period", cyc - last_stb, mon_e.gap);
                end
                last_stb = cyc;
            end
        end
    end

    // SOF, data bits (optionally stuffed), then 11 recessive bits outside the stuffed field
    task automatic build(input bit stuff_on, input int nbits, input logic [63:0] data);
        int run;
        bit last;
        bit b;
        lv.delete(); ds.delete(); du.delete(); gp.delete();
        lv.push_back(0); ds.push_back(1); du.push_back(BitClk); gp.push_back(0);
        run  = 1;
        last = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            b = data[i];
            lv.push_back(int'(b)); ds.push_back(1); du.push_back(BitClk); gp.push_back(BitClk);
            run  = (b == last) ? run + 1 : 1;
            last = b;
            if (stuff_on && run == 5) begin
                last = ~last;
                lv.push_back(int'(last)); ds.push_back(1); du.push_back(BitClk);
                gp.push_back(BitClk);
                run = 1;
            end
        end
        for (int i = 0; i < 11; i++) begin
            lv.push_back(1); ds.push_back(0); du.push_back(BitClk); gp.push_back(BitClk);
        end
    endtask

    // Reference: apply the receive rules bit by bit until the bus counts as idle
    task automatic model();
        int run  = 1;
        bit last = 1'b0;
        int rec  = 0;
        bit s;
        exp_t e;
        for (int i = 0; i < lv.size(); i++) begin
            s       = (lv[i] != 0);
            e.sbit  = s;
            e.valid = 1'b0;
            e.data  = s;
            e.err   = 1'b0;
            e.gap   = gp[i];
            if (i == 0 || ds[i] == 0) begin
                e.valid = 1'b1;
                run     = 1;
                last    = s;
            end else if (run == 5) begin
                if (s != last) begin
                    run  = 1;
                    last = s;
                end else begin
                    e.err = 1'b1;
                end
            end else begin
                e.valid = 1'b1;
                run     = (s == last) ? run + 1 : 1;
                last    = s;
            end
            rec    = s ? ((rec < 11) ? rec + 1 : 11) : 0;
            e.idle = (rec == 11);
            exp_q.push_back(e);
            if (e.idle) break;
        end
    endtask

    task automatic abort(input bit use_rst);
        if (use_rst) begin
            #2 rst = 1'b1;
            #1;
            check("rst_sample_stb", int'(sample_stb), 0);
            check("rst_bit_valid", int'(bit_valid), 0);
            check("rst_stuff_err", int'(stuff_err), 0);
            check("rst_sample_bit", int'(sample_bit), 1);
            check("rst_bit_data", int'(bit_data), 1);
            check("rst_bus_idle", int'(bus_idle), 1);
            can_rx = 1'b1;
            exp_q.delete();
            repeat (3) tick();
            rst = 1'b0;
        end else begin
            en = 1'b0;
            tick();
            tick();
            check("off_sample_stb", int'(sample_stb), 0);
            check("off_bit_valid", int'(bit_valid), 0);
            check("off_stuff_err", int'(stuff_err), 0);
            check("off_sample_bit", int'(sample_bit), 1);
            check("off_bit_data", int'(bit_data), 1);
            exp_q.delete();
            can_rx = 1'b1;
            repeat (5) tick();
            en = 1'b1;
        end
        repeat (100) tick();
    endtask

    task automatic send(input int abort_at, input bit use_rst);
        int t = 0;
        model();
        for (int i = 0; i < lv.size(); i++) begin
            can_rx     = (lv[i] != 0);
            destuff_en = (ds[i] != 0);
            if (i == 0) sof_cyc = cyc;
            for (int c = 0; c < du[i]; c++) begin
                tick();
                t++;
                if (abort_at > 0 && t == abort_at) begin
                    abort(use_rst);
                    return;
                end
            end
        end
        repeat (20) tick();
        check("queue_drained", exp_q.size(), 0);
        check("bus_idle_after_frame", int'(bus_idle), 1);
        repeat ($urandom_range(0, 30)) tick();
    endtask

    initial begin
        rst        = 1'b1;
        can_rx     = 1'b1;
        en         = 1'b0;
        destuff_en = 1'b0;
        frame_done = 1'b0;
        repeat (3) tick();
        check("reset_sample_stb", int'(sample_stb), 0);
        check("reset_bit_valid", int'(bit_valid), 0);
        check("reset_stuff_err", int'(stuff_err), 0);
        check("reset_sample_bit", int'(sample_bit), 1);
        check("reset_bit_data", int'(bit_data), 1);
        check("reset_bus_idle", int'(bus_idle), 1);
        rst = 1'b0;
        en  = 1'b1;
        repeat (10) tick();

        // SOF + four zeros, stuff 1, then 0
        build(1'b1, 5, 64'h0);
        send(0, 1'b0);

        // Six dominant samples with no stuff bit
        build(1'b0, 5, 64'h0);
        send(0, 1'b0);

        // Late edge: recessive bit held 16 clocks long, next bit seen at tq 3
        build(1'b1, 8, 64'h35);
        du[1] = BitClk + 16;
        gp[2] = 60;
        for (int i = 3; i < gp.size(); i++) gp[i] = -1;
        send(0, 1'b0);

        // Early edge: recessive bit cut 4 clocks short, next bit seen at tq 9
        build(1'b1, 8, 64'h35);
        du[1] = BitClk - 4;
        gp[2] = 45;
        for (int i = 3; i < gp.size(); i++) gp[i] = -1;
        send(0, 1'b0);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            build(1'b1, $urandom_range(8, 32), {$urandom, $urandom});
            send(0, 1'b0);
        end

        // Mid-frame reset, then mid-frame disable, then a clean frame
        build(1'b1, 24, {$urandom, $urandom});
        send(8 * BitClk + 13, 1'b1);
        build(1'b1, 24, {$urandom, $urandom});
        send(6 * BitClk + 27, 1'b0);
        build(1'b1, 16, {$urandom, $urandom});
        send(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
